// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store engine between the single-cycle
// RV32I datapath and a req/ack data bus. It sizes each access, steers byte
// lanes, detects misaligned addresses, extends load data, times out a silent
// bus and stalls the core until the access retires.
module load_store_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        f3,
    input  logic [31:0]       addr,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    output logic              stall,
    output logic              misalign,
    output logic              busErr,
    output logic              busReq,
    output logic              busWe,
    output logic [ADDR_W-1:0] busAddr,
    output logic [3:0]        busBe,
    output logic [31:0]       busWdata,
    input  logic [31:0]       busRdata,
    input  logic              busAck
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam int              CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    // Byte enables for a size code (00 byte, 01 half, 1x word) and offset.
    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate store data across every lane; byte enables pick the live one.
    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        case (sz)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Align the addressed lane to bit 0 and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic uns,
                                                 input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rd >> {off, 3'b000};
        case (sz)
            2'b00:   v = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   v = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: v = sh;
        endcase
        return v;
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       readData_q, readData_d;
    logic              busReq_q, busReq_d;
    logic              busWe_q, busWe_d;
    logic [ADDR_W-1:0] busAddr_q, busAddr_d;
    logic [3:0]        busBe_q, busBe_d;
    logic [31:0]       busWdata_q, busWdata_d;
    logic              misalign_q, misalign_d;
    logic              busErr_q, busErr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;

    logic              acc;
    logic              mis;
    logic [CNT_W-1:0]  cnt_inc;
    // Address bits above ADDR_W are intentionally dropped.
    logic [31:0]       unused_addr;

    assign unused_addr = addr;
    assign acc     = memRead | memWrite;
    assign mis     = ((f3[1:0] == 2'b01) & addr[0]) | (f3[1] & (addr[1:0] != 2'b00));
    assign cnt_inc = cnt_q + CNT_W'(1);

    // Core stall: hold the instruction while an access is being accepted or is on the bus.
    assign stall = rst_n & (((state_q == IDLE) & acc) | (state_q == REQ));

    assign readData = readData_q;
    assign busReq   = busReq_q;
    assign busWe    = busWe_q;
    assign busAddr  = busAddr_q;
    assign busBe    = busBe_q;
    assign busWdata = busWdata_q;
    assign misalign = misalign_q;
    assign busErr   = busErr_q;

    // Next-state logic: access acceptance, bus wait/timeout and retirement.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        readData_d = readData_q;
        busReq_d   = busReq_q;
        busWe_d    = busWe_q;
        busAddr_d  = busAddr_q;
        busBe_d    = busBe_q;
        busWdata_d = busWdata_q;
        misalign_d = 1'b0;
        busErr_d   = 1'b0;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (mis) begin
                        state_d    = ERR;
                        misalign_d = 1'b1;
                        readData_d = 32'h0;
                    end else begin
                        state_d    = REQ;
                        cnt_d      = '0;
                        busReq_d   = 1'b1;
                        busWe_d    = memWrite;
                        busAddr_d  = {addr[ADDR_W-1:2], 2'b00};
                        busBe_d    = lane_be(f3[1:0], addr[1:0]);
                        busWdata_d = lane_wdata(f3[1:0], writeData);
                        size_d     = f3[1:0];
                        uns_d      = f3[2];
                        off_d      = addr[1:0];
                    end
                end
            end
            REQ: begin
                // An ack on the final allowed cycle still completes the access.
                if (busAck) begin
                    state_d  = DONE;
                    busReq_d = 1'b0;
                    if (!busWe_q) begin
                        readData_d = load_extract(size_q, uns_q, off_q, busRdata);
                    end
                end else if (cnt_inc == TIMEOUT_C) begin
                    state_d    = ERR;
                    busReq_d   = 1'b0;
                    busErr_d   = 1'b1;
                    readData_d = 32'h0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            readData_q <= 32'h0;
            busReq_q   <= 1'b0;
            busWe_q    <= 1'b0;
            busAddr_q  <= '0;
            busBe_q    <= 4'h0;
            busWdata_q <= 32'h0;
            misalign_q <= 1'b0;
            busErr_q   <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readData_q <= readData_d;
            busReq_q   <= busReq_d;
            busWe_q    <= busWe_d;
            busAddr_q  <= busAddr_d;
            busBe_q    <= busBe_d;
            busWdata_q <= busWdata_d;
            misalign_q <= misalign_d;
            busErr_q   <= busErr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized accesses checked against a
// transaction-level reference model of the load/store unit.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        stall;
    logic        misalign;
    logic        busErr;
    logic        busReq;
    logic        busWe;
    logic [15:0] busAddr;
    logic [3:0]  busBe;
    logic [31:0] busWdata;
    logic [31:0] busRdata;
    logic        busAck;

    int          n_total;
    int          n_bad;
    logic [31:0] model_rd;

    load_store_unit #(.ADDR_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .memRead(memRead), .memWrite(memWrite),
        .f3(f3), .addr(addr), .writeData(writeData), .readData(readData),
        .stall(stall), .misalign(misalign), .busErr(busErr), .busReq(busReq),
        .busWe(busWe), .busAddr(busAddr), .busBe(busBe), .busWdata(busWdata),
        .busRdata(busRdata), .busAck(busAck)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: load result from the bus word, size, signedness and offset.
    function automatic logic [31:0] ref_load(input logic [2:0] f, input int unsigned off,
                                             input logic [31:0] rdat);
        logic [31:0] v;
        v = rdat >> (8 * off);
        if (f[1]) return v;
        if (f[0]) begin
            v = v % 65536;
            if (!f[2] && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = v % 256;
            if (!f[2] && v >= 128) v = v + 32'hFFFF_FF00;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f, input int unsigned off);
        if (f[1]) return 32'd15;
        if (f[0]) return (off >= 2) ? 32'd12 : 32'd3;
        return 32'd1 << off;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] f, input logic [31:0] wd);
        if (f[1]) return wd;
        if (f[0]) return (wd % 65536) * 32'h0001_0001;
        return (wd % 256) * 32'h0101_0101;
    endfunction

    // One instruction: ack_at is the REQ cycle (1-based) carrying busAck; beyond TO means none.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdat, input int ack_at);
        int unsigned off;
        logic        is_mis;
        logic [31:0] e_addr;
        logic [31:0] e_be;
        logic [31:0] e_wd;
        bit          timed_out;
        off    = a % 4;
        is_mis = (f[1] && off != 0) || (f[1:0] == 2'b01 && (off % 2) == 1);
        e_addr = ((a % 65536) / 4) * 4;
        e_be   = ref_be(f, off);
        e_wd   = ref_wd(f, wd);

        memRead = rd; memWrite = wr; f3 = f; addr = a; writeData = wd;
        busAck = 1'($urandom_range(0, 1));
        busRdata = $urandom;
        @(negedge clk);
        check_eq("idle_stall", stall, 1);
        check_eq("idle_busReq", busReq, 0);
        @(posedge clk); #1;
        busAck = 1'b0;

        if (is_mis) begin
            @(negedge clk);
            check_eq("mis_pulse", misalign, 1);
            check_eq("mis_busErr", busErr, 0);
            check_eq("mis_busReq", busReq, 0);
            check_eq("mis_stall", stall, 0);
            check_eq("mis_readData", readData, 0);
            model_rd = 32'h0;
        end else begin
            timed_out = 0;
            for (int j = 1; j <= TO; j++) begin
                busAck   = (j == ack_at);
                busRdata = (j == ack_at) ? rdat : $urandom;
                addr      = $urandom;
                writeData = $urandom;
                @(negedge clk);
                check_eq("req_busReq", busReq, 1);
                check_eq("req_stall", stall, 1);
                check_eq("req_busAddr", busAddr, e_addr);
                check_eq("req_busBe", busBe, e_be);
                check_eq("req_busWe", busWe, wr);
                check_eq("req_busWdata", busWdata, e_wd);
                check_eq("req_busErr", busErr, 0);
                @(posedge clk); #1;
                if (j == ack_at) break;
                if (j == TO) timed_out = 1;
            end
            busAck = 1'b0;
            @(negedge clk);
            check_eq("end_busReq", busReq, 0);
            check_eq("end_stall", stall, 0);
            check_eq("end_misalign", misalign, 0);
            if (timed_out) begin
                model_rd = 32'h0;
                check_eq("to_busErr", busErr, 1);
            end else begin
                if (!wr) model_rd = ref_load(f, off, rdat);
                check_eq("done_busErr", busErr, 0);
            end
            check_eq("end_readData", readData, model_rd);
        end
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    initial begin
        n_total = 0; n_bad = 0; model_rd = 32'h0;
        rst_n = 1'b0; memRead = 1'b1; memWrite = 1'b0; f3 = 3'b010;
        addr = 32'h0; writeData = 32'h0; busRdata = 32'h0; busAck = 1'b0;
        #3;
        check_eq("rst_stall", stall, 0);
        check_eq("rst_busReq", busReq, 0);
        check_eq("rst_readData", readData, 0);
        check_eq("rst_busAddr", busAddr, 0);
        check_eq("rst_busBe", busBe, 0);
        check_eq("rst_busWdata", busWdata, 0);
        check_eq("rst_busWe", busWe, 0);
        check_eq("rst_misalign", misalign, 0);
        check_eq("rst_busErr", busErr, 0);
        memRead = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_access(1, 0, 3'b010, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 1);
        check_eq("lw_const", readData, 32'hDEAD_BEEF);
        check_eq("lw_addr", busAddr, 32'h0104);
        do_access(1, 0, 3'b000, 32'h0000_0203, 32'h0, 32'h80FF_0000, 1);
        check_eq("lb_const", readData, 32'hFFFF_FF80);
        check_eq("lb_be", busBe, 4'b1000);
        do_access(1, 0, 3'b100, 32'h0000_0203, 32'h0, 32'h80FF_0000, 2);
        check_eq("lbu_const", readData, 32'h0000_0080);
        do_access(1, 0, 3'b001, 32'h0000_0202, 32'h0, 32'h80FF_0000, 1);
        check_eq("lh_const", readData, 32'hFFFF_80FF);
        do_access(0, 1, 3'b000, 32'h0000_0301, 32'h1234_56AB, 32'h0, 1);
        check_eq("sb_wdata", busWdata, 32'hABAB_ABAB);
        check_eq("sb_be", busBe, 4'b0010);
        check_eq("sb_rd_hold", readData, 32'hFFFF_80FF);
        do_access(0, 1, 3'b001, 32'h0000_0302, 32'h1234_56AB, 32'h0, 3);
        check_eq("sh_wdata", busWdata, 32'h56AB_56AB);
        check_eq("sh_be", busBe, 4'b1100);
        do_access(1, 0, 3'b010, 32'h0000_0402, 32'h0, 32'h1111_1111, 1);
        check_eq("mis_rd_const", readData, 32'h0);
        do_access(1, 0, 3'b010, 32'h0000_0500, 32'h0, 32'h5555_AAAA, TO + 1);
        do_access(1, 0, 3'b010, 32'h0000_0504, 32'h0, 32'h5555_AAAA, TO);
        check_eq("ack_last_const", readData, 32'h5555_AAAA);

        // Reset in the middle of a wait-stated load
        memRead = 1'b1; f3 = 3'b010; addr = 32'h0000_0600; busAck = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busReq", busReq, 0);
        check_eq("mid_rst_stall", stall, 0);
        check_eq("mid_rst_readData", readData, 0);
        check_eq("mid_rst_busAddr", busAddr, 0);
        check_eq("mid_rst_busBe", busBe, 0);
        model_rd = 32'h0;
        memRead = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        busAck = 1'b1; busRdata = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("late_ack_busReq", busReq, 0);
        check_eq("late_ack_stall", stall, 0);
        @(posedge clk); #1;
        busAck = 1'b0;
        @(negedge clk);
        check_eq("late_ack_readData", readData, 0);
        @(posedge clk); #1;
        do_access(1, 0, 3'b010, 32'h0000_0700, 32'h0, 32'h0BAD_CAFE, 2);
        check_eq("post_rst_load", readData, 32'h0BAD_CAFE);

        // Randomized accesses, back-to-back or with an idle gap
        repeat (80) begin
            int unsigned kind;
            logic r, w;
            kind = $urandom_range(0, 2);
            r = (kind != 1);
            w = (kind != 0);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            do_access(r, w, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      int'($urandom_range(1, TO + 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
